// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_op, i_operand_a, i_operand_b,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_operand_a, i_operand_b,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product or quotient bit per cycle.
//
//  state   | meaning
//  --------+----------------------------------------------------------------
//  IDLE    | waiting for i_start; operands and op are latched on acceptance
//  CALC    | one shift-add / restoring-divide step per cycle; a latched
//          | special case (divide by zero, signed overflow) leaves after one
//  DONE    | o_done pulse, o_result valid; always returns to IDLE
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  // Decode incoming request: operand magnitudes, result sign, special cases.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    neg_in   = 1'b0;
    case (bus.i_op)
      OP_MULH, OP_DIV: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_in   = bus.i_operand_a[XLEN-1] ^ bus.i_operand_b[XLEN-1];
      end
      OP_MULHSU: begin
        a_signed = 1'b1;
        neg_in   = bus.i_operand_a[XLEN-1];
      end
      OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        neg_in   = bus.i_operand_a[XLEN-1];
      end
      default: ;
    endcase
    a_mag = (a_signed && bus.i_operand_a[XLEN-1]) ? -bus.i_operand_a : bus.i_operand_a;
    b_mag = (b_signed && bus.i_operand_b[XLEN-1]) ? -bus.i_operand_b : bus.i_operand_b;

    div_zero = bus.i_op[2] && (bus.i_operand_b == '0);
    div_ovf  = ((bus.i_op == OP_DIV) || (bus.i_op == OP_REM)) &&
               (bus.i_operand_a == MIN_NEG) && (bus.i_operand_b == '1);

    // op[1] separates the remainder ops from the quotient ops
    special_res = '0;
    if (div_zero) begin
      special_res = bus.i_op[1] ? bus.i_operand_a : '1;
    end else if (div_ovf) begin
      special_res = bus.i_op[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  // acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    if (op_q[2]) begin
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      if (!div_diff[XLEN]) begin
        acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix and result select applied to the value of the final iteration.
  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  // Sequencer: accept, iterate with a down-counter, pulse done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          op_d      = bus.i_op;
          neg_d     = neg_in;
          b_d       = b_mag;
          cnt_d     = CNT_LOAD;
          special_d = div_zero || div_ovf;
          acc_d     = (div_zero || div_ovf) ? {{XLEN{1'b0}}, special_res}
                                            : {{XLEN{1'b0}}, a_mag};
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        if (special_q) begin
          result_d = acc_q[XLEN-1:0];
          state_d  = ST_DONE;
        end else begin
          acc_d = acc_step;
          if (cnt_q == '0) begin
            result_d = final_res;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any op in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign bus.o_busy   = (state_q != ST_IDLE);
  assign bus.o_done   = (state_q == ST_DONE);
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus randomized ops against a
// reference built from plain 64-bit arithmetic.
module tb_muldiv_unit;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub, ua, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin up = 64'(ua * ub); return up[31:0]; end
      3'd1: begin sp = sa * sb; up = 64'(sp); return up[63:32]; end
      3'd2: begin sp = sa * ub; up = 64'(sp); return up[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        sp = sa / sb; up = 64'(sp); return up[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; up = 64'(sp); return up[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one op; count edges from the accepting edge until o_done is seen.
  // With disturb set, start is re-pulsed at +5 and in the done cycle, and
  // operands are scrambled while the op is in flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag, input bit disturb);
    int          n;
    int          extra;
    bit          seen;
    logic [31:0] exp;
    exp  = ref_result(op, a, b);
    seen = 1'b0;
    n    = 0;
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_op        = op;
    bus.i_operand_a = a;
    bus.i_operand_b = b;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      if (bus.o_done) begin
        seen = 1'b1;
        check({tag, "_result"}, bus.o_result, exp);
        check({tag, "_latency"}, 32'(n), 32'(ref_latency(op, a, b)));
      end
      bus.i_start = (disturb && (n == 5 || n == 33)) ? 1'b1 : 1'b0;
      if (disturb) begin
        bus.i_op        = 3'($urandom_range(0, 7));
        bus.i_operand_a = $urandom;
        bus.i_operand_b = $urandom;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    bus.i_start = 1'b0;
    check({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
    check({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_held"}, bus.o_result, exp);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.o_done) extra++;
      end
      check({tag, "_no_second_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int          extra;
    int          sel;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_op        = 3'd0;
    bus.i_operand_a = 32'd0;
    bus.i_operand_b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_result", bus.o_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(bus.o_busy), 32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3", 1'b0);
    run_op(3'd1, MIN_NEG, MIN_NEG, "mulh_min", 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_m1_2", 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b0);
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7", 1'b0);
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7", 1'b0);
    run_op(3'd4, 32'h1234_5678, 32'd0, "div_by0", 1'b0);
    run_op(3'd6, 32'h1234_5678, 32'd0, "rem_by0", 1'b0);
    run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
    run_op(3'd5, MIN_NEG, 32'hFFFF_FFFF, "divu_no_ovf", 1'b0);
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, "mulh_disturb", 1'b1);
    run_op(3'd4, 32'hFFFF_FC18, 32'd13, "div_disturb", 1'b1);

    // reset ten cycles into a divide aborts it without a done pulse
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_op        = 3'd4;
    bus.i_operand_a = 32'hFFFF_FF9C;
    bus.i_operand_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_done", 32'(bus.o_done), 32'd0);
    check("abort_result", bus.o_result, 32'd0);
    rst   = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, "div_after_rst", 1'b0);

    for (int i = 0; i < 30; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 20));
      if (sel == 3) a = {16'hFFFF, 16'($urandom)};
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
